// File: rtl/sensor_report_scheduler_if.sv
// Sensor scheduler bus bundle: sampling inputs, tx_busy, published report outputs.
// master = scheduler side (drives report outputs), slave = consumer/source side.
interface sensor_report_scheduler_if #(
    parameter int SPEED_SENSOR_WIDTH = 16,
    parameter int ADC_WIDTH          = 16
);
    logic                          ENABLE;
    logic [SPEED_SENSOR_WIDTH-1:0] SPEED_SENSOR_IN;
    logic [ADC_WIDTH-1:0]          ADC_IN;
    logic                          TX_BUSY;
    logic [SPEED_SENSOR_WIDTH-1:0] SPEED_SENSOR;
    logic [ADC_WIDTH-1:0]          ADC;
    logic                          SEND_PACKET;
    logic [15:0]                   REPORT_COUNT;
    logic                          OVERRUN;

    modport master (
        input  ENABLE, SPEED_SENSOR_IN, ADC_IN, TX_BUSY,
        output SPEED_SENSOR, ADC, SEND_PACKET, REPORT_COUNT, OVERRUN
    );

    modport slave (
        output ENABLE, SPEED_SENSOR_IN, ADC_IN, TX_BUSY,
        input  SPEED_SENSOR, ADC, SEND_PACKET, REPORT_COUNT, OVERRUN
    );
endinterface

// File: rtl/sensor_report_scheduler.sv
// Periodic sensor sampler/averager that publishes reports and pulses SEND_PACKET.
// Ports: CLOCK, RESET (async, active-high), bus (master modport of
// sensor_report_scheduler_if: ENABLE, SPEED_SENSOR_IN, ADC_IN, TX_BUSY in;
// SPEED_SENSOR, ADC, SEND_PACKET, REPORT_COUNT, OVERRUN out).
// Option: define SENSOR_AVG_EN to average 2^AVG_LOG2 samples per report;
// undefined, every strobe publishes the raw sample taken on that strobe.
module sensor_report_scheduler #(
    parameter int SPEED_SENSOR_WIDTH = 16,
    parameter int ADC_WIDTH          = 16,
    parameter int SAMPLE_PERIOD      = 25000,
    parameter int AVG_LOG2           = 3
) (
    input logic                       CLOCK,
    input logic                       RESET,
    sensor_report_scheduler_if.master bus
);
`ifdef SENSOR_AVG_EN
    localparam int LG = AVG_LOG2;
`else
    // raw mode: one sample per report, averaging depth has no effect
    localparam int LG = AVG_LOG2 - AVG_LOG2;
`endif
    localparam int CW  = $clog2(SAMPLE_PERIOD);
    localparam int NW  = LG + 1;
    localparam int SAW = SPEED_SENSOR_WIDTH + LG;
    localparam int AAW = ADC_WIDTH + LG;
    localparam logic [CW-1:0] CNT_MAX  = CW'(SAMPLE_PERIOD - 1);
    localparam logic [NW-1:0] IDX_LAST = NW'((1 << LG) - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, PUBLISH} state_t;

    state_t                        state;
    logic [CW-1:0]                 cnt;
    logic [NW-1:0]                 idx;
    logic [SAW-1:0]                speed_acc;
    logic [AAW-1:0]                adc_acc;
    logic [SPEED_SENSOR_WIDTH-1:0] speed_q;
    logic [ADC_WIDTH-1:0]          adc_q;
    logic                          send_q;
    logic [15:0]                   count_q;
    logic                          overrun_q;

    logic          strobe;
    logic [CW-1:0] cnt_next;

    assign strobe   = (cnt == CNT_MAX);
    assign cnt_next = strobe ? '0 : cnt + 1'b1;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            speed_acc <= '0;
            adc_acc   <= '0;
            speed_q   <= '0;
            adc_q     <= '0;
            send_q    <= 1'b0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            send_q <= 1'b0;
            case (state)
                IDLE: begin
                    cnt       <= '0;
                    idx       <= '0;
                    speed_acc <= '0;
                    adc_acc   <= '0;
                    if (bus.ENABLE)
                        state <= ACCUM;
                end
                ACCUM: begin
                    if (!bus.ENABLE) begin
                        // partial sum is abandoned
                        state     <= IDLE;
                        cnt       <= '0;
                        idx       <= '0;
                        speed_acc <= '0;
                        adc_acc   <= '0;
                    end else begin
                        cnt <= cnt_next;
                        if (strobe) begin
`ifdef SENSOR_AVG_EN
                            speed_acc <= speed_acc + SAW'(bus.SPEED_SENSOR_IN);
                            adc_acc   <= adc_acc + AAW'(bus.ADC_IN);
`else
                            speed_acc <= bus.SPEED_SENSOR_IN;
                            adc_acc   <= bus.ADC_IN;
`endif
                            idx <= idx + 1'b1;
                            if (idx == IDX_LAST)
                                state <= PUBLISH;
                        end
                    end
                end
                PUBLISH: begin
                    if (!bus.TX_BUSY) begin
                        speed_q <= speed_acc[LG +: SPEED_SENSOR_WIDTH];
                        adc_q   <= adc_acc[LG +: ADC_WIDTH];
                        send_q  <= 1'b1;
                        count_q <= count_q + 16'd1;
                    end else begin
                        overrun_q <= 1'b1;
                    end
                    idx       <= '0;
                    speed_acc <= '0;
                    adc_acc   <= '0;
                    // sample cadence keeps running through the publish cycle
                    if (bus.ENABLE) begin
                        state <= ACCUM;
                        cnt   <= cnt_next;
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.SPEED_SENSOR = speed_q;
    assign bus.ADC          = adc_q;
    assign bus.SEND_PACKET  = send_q;
    assign bus.REPORT_COUNT = count_q;
    assign bus.OVERRUN      = overrun_q;
endmodule

// File: tb/tb_sensor_report_scheduler.sv
// Directed bench for sensor_report_scheduler (SAMPLE_PERIOD=4, AVG_LOG2=2).
// Covers averaging scenarios with SENSOR_AVG_EN, raw publishing without it.
module tb_sensor_report_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int pulses  = 0;
    int wide    = 0;
    int pulse_cyc [64];
    int pulse_adc [64];
    logic send_prev = 1'b0;

    sensor_report_scheduler_if #(
        .SPEED_SENSOR_WIDTH(16),
        .ADC_WIDTH(16)
    ) bus ();

    sensor_report_scheduler #(
        .SPEED_SENSOR_WIDTH(16),
        .ADC_WIDTH(16),
        .SAMPLE_PERIOD(4),
        .AVG_LOG2(2)
    ) dut (
        .CLOCK(clk),
        .RESET(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst && bus.SEND_PACKET) begin
            if (pulses < 64) begin
                pulse_cyc[pulses] = cyc;
                pulse_adc[pulses] = int'(bus.ADC);
            end
            pulses++;
            if (send_prev)
                wide++;
        end
        send_prev = bus.SEND_PACKET;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic window(input logic [15:0] s, input logic [15:0] a);
        bus.SPEED_SENSOR_IN = s;
        bus.ADC_IN          = a;
        repeat (4) step();
    endtask

    task automatic start();
        bus.ENABLE = 1'b1;
        step();
    endtask

    // called in the publish cycle; drops ENABLE, which must not stop it
    task automatic close_report(input logic exp_send);
        bus.ENABLE = 1'b0;
        step();
        chk("send_pulse", 32'(bus.SEND_PACKET), 32'(exp_send));
        step();
        chk("send_low", 32'(bus.SEND_PACKET), 32'd0);
    endtask

    task automatic chk_out(input string tag, input logic [15:0] s,
                           input logic [15:0] a, input logic [15:0] c,
                           input logic o);
        chk({tag, "_speed"}, 32'(bus.SPEED_SENSOR), 32'(s));
        chk({tag, "_adc"}, 32'(bus.ADC), 32'(a));
        chk({tag, "_count"}, 32'(bus.REPORT_COUNT), 32'(c));
        chk({tag, "_overrun"}, 32'(bus.OVERRUN), 32'(o));
    endtask

    initial begin
        bus.ENABLE          = 1'b0;
        bus.SPEED_SENSOR_IN = '0;
        bus.ADC_IN          = '0;
        bus.TX_BUSY         = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk_out("reset", 16'h0, 16'h0, 16'd0, 1'b0);
        chk("reset_send", 32'(bus.SEND_PACKET), 32'd0);

`ifdef SENSOR_AVG_EN
        // constant inputs
        start();
        repeat (4) window(16'hDEAD, 16'hBEEF);
        close_report(1'b1);
        chk_out("const", 16'hDEAD, 16'hBEEF, 16'd1, 1'b0);
        chk("const_pulses", 32'(pulses), 32'd1);

        // ramp: speed 10+20+30+41=101 -> 25, adc 1+2+3+4=10 -> 2
        start();
        window(16'd10, 16'd1);
        window(16'd20, 16'd2);
        window(16'd30, 16'd3);
        window(16'd41, 16'd4);
        close_report(1'b1);
        chk_out("ramp", 16'd25, 16'h0002, 16'd2, 1'b0);

        // full scale, no overflow
        start();
        repeat (4) window(16'hFFFF, 16'hFFFF);
        close_report(1'b1);
        chk_out("full", 16'hFFFF, 16'hFFFF, 16'd3, 1'b0);

        // busy drop
        start();
        repeat (4) window(16'h1000, 16'h2000);
        bus.TX_BUSY = 1'b1;
        close_report(1'b0);
        bus.TX_BUSY = 1'b0;
        chk_out("busy", 16'hFFFF, 16'hFFFF, 16'd3, 1'b1);
        start();
        repeat (4) window(16'h0100, 16'h0200);
        close_report(1'b1);
        chk_out("after_busy", 16'h0100, 16'h0200, 16'd4, 1'b1);

        // abort after 2 strobes; next report uses fresh samples only
        start();
        repeat (2) window(16'h5555, 16'h5555);
        bus.ENABLE = 1'b0;
        repeat (3) step();
        chk("abort_pulses", 32'(pulses), 32'd4);
        start();
        repeat (4) window(16'h0008, 16'h0004);
        close_report(1'b1);
        chk_out("abort", 16'h0008, 16'h0004, 16'd5, 1'b1);

        // back-to-back reports keep a 16-cycle cadence
        start();
        repeat (4) window(16'h0010, 16'h0020);
        repeat (4) window(16'h0030, 16'h0040);
        close_report(1'b1);
        chk_out("b2b", 16'h0030, 16'h0040, 16'd7, 1'b1);
        chk("b2b_pulses", 32'(pulses), 32'd7);
        chk("b2b_first_adc", 32'(pulse_adc[5]), 32'h20);
        chk("b2b_spacing", 32'(pulse_cyc[6] - pulse_cyc[5]), 32'd16);
        chk("pulse_width", 32'(wide), 32'd0);
`else
        // raw ramp: four reports publish 1, 2, 3, 4
        start();
        window(16'hDEAD, 16'd1);
        window(16'hDEAD, 16'd2);
        window(16'hDEAD, 16'd3);
        window(16'hDEAD, 16'd4);
        close_report(1'b1);
        chk("raw_pulses", 32'(pulses), 32'd4);
        chk("raw_adc0", 32'(pulse_adc[0]), 32'd1);
        chk("raw_adc1", 32'(pulse_adc[1]), 32'd2);
        chk("raw_adc2", 32'(pulse_adc[2]), 32'd3);
        chk("raw_adc3", 32'(pulse_adc[3]), 32'd4);
        chk("raw_spacing", 32'(pulse_cyc[3] - pulse_cyc[0]), 32'd12);
        chk("pulse_width", 32'(wide), 32'd0);
        chk_out("raw", 16'hDEAD, 16'd4, 16'd4, 1'b0);

        // busy drop
        start();
        window(16'h1234, 16'h1234);
        bus.TX_BUSY = 1'b1;
        close_report(1'b0);
        bus.TX_BUSY = 1'b0;
        chk_out("busy", 16'hDEAD, 16'd4, 16'd4, 1'b1);
        start();
        window(16'h0777, 16'h0888);
        close_report(1'b1);
        chk_out("after_busy", 16'h0777, 16'h0888, 16'd5, 1'b1);
        chk("busy_pulses", 32'(pulses), 32'd5);
`endif

        // reset mid-accumulation
        start();
        window(16'h4321, 16'h1234);
        step();
        rst = 1'b1;
        step();
        chk_out("rst_mid", 16'h0, 16'h0, 16'd0, 1'b0);
        chk("rst_mid_send", 32'(bus.SEND_PACKET), 32'd0);
        bus.ENABLE = 1'b0;
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
